processor_status: RTL and testbench
===================================

// Module: processor_status
// PURPOSE
// - 6502 processor status (P) register, directly downstream of the ALU: consumes result, carry, overflow and status-write strobe.
// - Derives N/Z/C/V and applies flag set/clear ops and PLP/RTI pulls.
// - Sequences the P-push half of BRK/IRQ entry.
// - Feeds carry_in and dec_mode back to the ALU for the next operation.
// PARAMETERS
// - RESET_FLAGS  8'h04  stored-flag value after reset: I=1, all other flags 0.
// PORTS
// - phi1          in   1          system clock; all state updates on posedge phi1.
// - reset         in   1          synchronous, active-high reset.
// - alu_dout      in   REG_WIDTH  ALU result.
// - alu_carry     in   1          ALU carry_out.
// - alu_overflow  in   1          ALU overflow.
// - alu_valid     in   1          ALU status-write strobe (wout_status); qualifies the three ALU inputs.
// - upd_mask      in   8          per-P-bit update enable for ALU-derived flags; bits 5,4,3,2 ignored.
// - bit_test      in   1          BIT instruction: N,V taken from bit_operand instead of the ALU.
// - bit_operand   in   REG_WIDTH  memory operand for BIT.
// - flag_op       in   3          0 NOP, 1 SEC, 2 CLC, 3 SEI, 4 CLI, 5 SED, 6 CLD, 7 CLV.
// - pull_valid    in   1          PLP/RTI load strobe.
// - pull_data     in   8          stack byte for PLP/RTI.
// - irq_req       in   1          maskable interrupt request (level).
// - brk_req       in   1          BRK entry request (1-cycle pulse).
// - push_ack      in   1          stack unit accepted push_data.
// - status        out  8          P = {N,V,1,1,D,I,Z,C}.
// - carry_in      out  1          = C.
// - dec_mode      out  1          = D.
// - irq_mask      out  1          = I.
// - push_data     out  8          P image for the stack: bit5=1, bit4=B.
// - push_valid    out  1          push_data valid; held until push_ack.
// - int_busy      out  1          FSM not in IDLE; decoder must stall.
// BEHAVIOUR
// - Reset: flags=RESET_FLAGS (status=8'h34), FSM=IDLE, push_valid=0, push_data=8'h00, int_busy=0. Reset wins over every other input, in any state.
// - Storage: six flags only. Bit5 and bit4 of status always read 1; B exists only in push_data.
// - Latency: all updates are registered; visible on status the cycle after the strobe.
// - ALU update (IDLE, alu_valid=1), applied only where upd_mask bit=1:
//   - N=alu_dout[7]; Z=(alu_dout==0); C=alu_carry; V=alu_overflow.
//   - With bit_test=1: N=bit_operand[7], V=bit_operand[6]; Z still from alu_dout.
// - Same-cycle priority in IDLE: pull_valid > flag_op > ALU update.
//   - flag_op wins on the bit it targets; ALU update still applies to other masked bits.
//   - pull_valid overrides both: loads N,V,D,I,Z,C from pull_data bits 7,6,3,2,1,0.
// - FSM states: IDLE -> PUSH -> MASK -> IDLE.
//   - IDLE->PUSH on brk_req, or on irq_req with I=0 (I sampled before that cycle's updates). brk_req has priority.
//   - The same cycle's updates are still applied; the pushed image reflects them.
//   - PUSH: push_valid=1; push_data={N,V,1,B,D,I,Z,C}, with B=1 for BRK and 0 for IRQ. Held stable until push_ack; on push_ack -> MASK.
//   - MASK: set I=1, then -> IDLE. push_valid=0.
//   - Non-IDLE states: alu_valid, flag_op, pull_valid, irq_req and brk_req are ignored (no effect).
// - Reset mid-sequence: next cycle FSM=IDLE, push_valid=0, flags=RESET_FLAGS.
// CONFIGURATION
// - STATUS_CMOS_DCLR_EN defined: MASK state also clears D (65C02 behaviour).
// - Not defined: D is preserved through interrupt entry (NMOS behaviour).
// STRUCTURE
// - Shared defines header holds: REG_WIDTH; flag bit indices FLAG_C=0, FLAG_Z=1, FLAG_I=2, FLAG_D=3, FLAG_B=4, FLAG_U=5, FLAG_V=6, FLAG_N=7; FLAG_OP_* encodings; FSM state encodings.
// - Sub-module status_flag_calc: combinational N/Z/C/V derivation from ALU/BIT inputs and upd_mask.
// - Top level holds the register, priority logic and FSM.
// TESTING
// - Reset: status=8'h34, carry_in=0, dec_mode=0, push_valid=0, int_busy=0.
// - alu_valid, alu_dout=8'h00, alu_carry=1, upd_mask=8'h83 -> status=8'h37 next cycle.
// - Same cycle: flag_op=SED, alu_valid, upd_mask=8'h01, alu_carry=1 -> status=8'h3D, dec_mode=1.
// - Same cycle: pull_data=8'hC3 with pull_valid, alu_valid, flag_op=SEI -> status=8'hF3.
// - CLI, then irq_req with push_ack delayed 3 cycles:
//   - push_data=8'h20 held stable for 3 cycles with push_valid=1.
//   - status=8'h34 after MASK.
//   - With STATUS_CMOS_DCLR_EN and D=1: D=0 after MASK; without the macro: D=1.
// - irq_req with I=1 -> no push.
//   - brk_req instead -> push_data=8'h34.
//   - Reset asserted in PUSH -> IDLE, push_valid=0 next cycle.

Source files
------------

// File: rtl/processor_status_pkg.sv
// processor_status_pkg: shared widths, P-register bit indices, flag-op and FSM encodings.
// Ports: none (package only).
// Imported by status_flag_calc and processor_status.
package processor_status_pkg;

  localparam int REG_WIDTH = 8;

  // Bit positions inside the P image {N,V,U,B,D,I,Z,C}
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_D = 3;
  localparam int FLAG_B = 4;
  localparam int FLAG_U = 5;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  // Bits of P that are not stored: U always reads 1, B lives only in the push image
  localparam logic [7:0] UNSTORED_MASK = 8'h30;
  // Bits an ALU status write may touch
  localparam logic [7:0] ALU_FLAG_MASK = 8'hC3;

  localparam logic [2:0] FLAG_OP_NOP = 3'd0;
  localparam logic [2:0] FLAG_OP_SEC = 3'd1;
  localparam logic [2:0] FLAG_OP_CLC = 3'd2;
  localparam logic [2:0] FLAG_OP_SEI = 3'd3;
  localparam logic [2:0] FLAG_OP_CLI = 3'd4;
  localparam logic [2:0] FLAG_OP_SED = 3'd5;
  localparam logic [2:0] FLAG_OP_CLD = 3'd6;
  localparam logic [2:0] FLAG_OP_CLV = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_MASK = 2'd2
  } state_e;

endpackage

// File: rtl/processor_status_flag_calc.sv
// status_flag_calc: combinational N/Z/C/V derivation from ALU or BIT inputs.
// Ports: ALU result/carry/overflow/strobe, upd_mask, bit_test/bit_operand in;
//        o_flag_en (per-P-bit write enable) and o_flag_val (new value) out, P bit layout.
module status_flag_calc
  import processor_status_pkg::*;
(
  input  logic [REG_WIDTH-1:0] i_alu_dout,
  input  logic                 i_alu_carry,
  input  logic                 i_alu_overflow,
  input  logic                 i_alu_valid,
  input  logic [7:0]           i_upd_mask,
  input  logic                 i_bit_test,
  input  logic [REG_WIDTH-1:0] i_bit_operand,
  output logic [7:0]           o_flag_en,
  output logic [7:0]           o_flag_val
);

  // Only bits 7 and 6 of the BIT operand matter
  logic w_unused;
  assign w_unused = ^i_bit_operand[REG_WIDTH-3:0];

  always_comb begin
    // Mask bits 5..2 are dropped by ALU_FLAG_MASK
    o_flag_en  = i_upd_mask & ALU_FLAG_MASK & {8{i_alu_valid}};
    o_flag_val = 8'h00;
    o_flag_val[FLAG_N] = i_bit_test ? i_bit_operand[REG_WIDTH-1] : i_alu_dout[REG_WIDTH-1];
    o_flag_val[FLAG_V] = i_bit_test ? i_bit_operand[REG_WIDTH-2] : i_alu_overflow;
    o_flag_val[FLAG_Z] = (i_alu_dout == '0);
    o_flag_val[FLAG_C] = i_alu_carry;
  end

endmodule

// File: rtl/processor_status.sv
// processor_status: 6502 P register with ALU/flag-op/pull updates and the P-push half of BRK/IRQ entry.
// Ports: phi1/reset; ALU result+strobe, upd_mask, BIT inputs, flag_op, pull_valid/pull_data,
//        irq_req/brk_req/push_ack in; status, carry_in, dec_mode, irq_mask, push_data/push_valid, int_busy out.
// Build option STATUS_CMOS_DCLR_EN: interrupt entry also clears D (65C02); default preserves D (NMOS).
module processor_status
  import processor_status_pkg::*;
#(
  parameter logic [7:0] RESET_FLAGS = 8'h04
) (
  input  logic                 phi1,
  input  logic                 reset,
  input  logic [REG_WIDTH-1:0] alu_dout,
  input  logic                 alu_carry,
  input  logic                 alu_overflow,
  input  logic                 alu_valid,
  input  logic [7:0]           upd_mask,
  input  logic                 bit_test,
  input  logic [REG_WIDTH-1:0] bit_operand,
  input  logic [2:0]           flag_op,
  input  logic                 pull_valid,
  input  logic [7:0]           pull_data,
  input  logic                 irq_req,
  input  logic                 brk_req,
  input  logic                 push_ack,
  output logic [7:0]           status,
  output logic                 carry_in,
  output logic                 dec_mode,
  output logic                 irq_mask,
  output logic [7:0]           push_data,
  output logic                 push_valid,
  output logic                 int_busy
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [7:0] r_flags;      // P layout; bits 5,4 held at 0
  logic [7:0] w_flags_nxt;
  logic       r_brk;        // B value for the pending push
  logic [7:0] w_alu_en;
  logic [7:0] w_alu_val;
  logic       w_take;

  status_flag_calc u_flag_calc (
    .i_alu_dout    (alu_dout),
    .i_alu_carry   (alu_carry),
    .i_alu_overflow(alu_overflow),
    .i_alu_valid   (alu_valid),
    .i_upd_mask    (upd_mask),
    .i_bit_test    (bit_test),
    .i_bit_operand (bit_operand),
    .o_flag_en     (w_alu_en),
    .o_flag_val    (w_alu_val)
  );

  // I is the registered value, so a CLI in this cycle cannot admit an IRQ in this cycle
  assign w_take = brk_req | (irq_req & ~r_flags[FLAG_I]);

  // State register
  always_ff @(posedge phi1) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_brk   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_take) r_brk <= brk_req;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_take)   w_state_nxt = ST_PUSH;
      ST_PUSH: if (push_ack) w_state_nxt = ST_MASK;
      ST_MASK:               w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  // Flag update: pull > flag_op > ALU, only in IDLE; MASK sets I
  always_comb begin
    w_flags_nxt = r_flags;
    case (r_state)
      ST_IDLE: begin
        if (pull_valid) begin
          w_flags_nxt = pull_data & ~UNSTORED_MASK;
        end else begin
          w_flags_nxt = (r_flags & ~w_alu_en) | (w_alu_val & w_alu_en);
          case (flag_op)
            FLAG_OP_SEC: w_flags_nxt[FLAG_C] = 1'b1;
            FLAG_OP_CLC: w_flags_nxt[FLAG_C] = 1'b0;
            FLAG_OP_SEI: w_flags_nxt[FLAG_I] = 1'b1;
            FLAG_OP_CLI: w_flags_nxt[FLAG_I] = 1'b0;
            FLAG_OP_SED: w_flags_nxt[FLAG_D] = 1'b1;
            FLAG_OP_CLD: w_flags_nxt[FLAG_D] = 1'b0;
            FLAG_OP_CLV: w_flags_nxt[FLAG_V] = 1'b0;
            default:     ;
          endcase
        end
      end
      ST_MASK: begin
        w_flags_nxt[FLAG_I] = 1'b1;
`ifdef STATUS_CMOS_DCLR_EN
        w_flags_nxt[FLAG_D] = 1'b0;
`else
        w_flags_nxt[FLAG_D] = r_flags[FLAG_D];
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge phi1) begin
    if (reset) r_flags <= RESET_FLAGS & ~UNSTORED_MASK;
    else       r_flags <= w_flags_nxt;
  end

  // Outputs; flags cannot change in PUSH, so push_data is stable until push_ack
  always_comb begin
    status         = r_flags | UNSTORED_MASK;
    carry_in       = r_flags[FLAG_C];
    dec_mode       = r_flags[FLAG_D];
    irq_mask       = r_flags[FLAG_I];
    push_valid     = (r_state == ST_PUSH);
    int_busy       = (r_state != ST_IDLE);
    push_data      = 8'h00;
    if (r_state == ST_PUSH) begin
      push_data         = r_flags;
      push_data[FLAG_U] = 1'b1;
      push_data[FLAG_B] = r_brk;
    end
  end

endmodule

// File: tb/tb_processor_status.sv
// tb_processor_status: directed vectors with hand-computed P values.
// Ports: none (top-level bench).
// Prints one summary line: CHECKS n ERRORS m.
module tb_processor_status;
  import processor_status_pkg::*;

  logic       phi1 = 1'b0;
  logic       reset;
  logic [7:0] alu_dout, bit_operand, pull_data, upd_mask;
  logic       alu_carry, alu_overflow, alu_valid, bit_test;
  logic [2:0] flag_op;
  logic       pull_valid, irq_req, brk_req, push_ack;
  logic [7:0] status, push_data;
  logic       carry_in, dec_mode, irq_mask, push_valid, int_busy;

  int checks = 0;
  int errors = 0;

  always #5 phi1 = ~phi1;

  processor_status dut (
    .phi1(phi1), .reset(reset),
    .alu_dout(alu_dout), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_valid(alu_valid), .upd_mask(upd_mask), .bit_test(bit_test),
    .bit_operand(bit_operand), .flag_op(flag_op), .pull_valid(pull_valid),
    .pull_data(pull_data), .irq_req(irq_req), .brk_req(brk_req), .push_ack(push_ack),
    .status(status), .carry_in(carry_in), .dec_mode(dec_mode), .irq_mask(irq_mask),
    .push_data(push_data), .push_valid(push_valid), .int_busy(int_busy)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; alu_dout = 8'h00; alu_carry = 1'b0; alu_overflow = 1'b0;
    alu_valid = 1'b0; upd_mask = 8'h00; bit_test = 1'b0; bit_operand = 8'h00;
    flag_op = FLAG_OP_NOP; pull_valid = 1'b0; pull_data = 8'h00;
    irq_req = 1'b0; brk_req = 1'b0; push_ack = 1'b0;
  endtask

  // One clock; inputs return to idle and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge phi1);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
  endtask

  logic [7:0] exp_d_after;

  initial begin
    idle_inputs();
    reset = 1'b1;
    #2;
    tick();
    tick();
    chk("rst_status", status, 8'h34);
    chk("rst_carry_in", {7'd0, carry_in}, 8'h00);
    chk("rst_dec_mode", {7'd0, dec_mode}, 8'h00);
    chk("rst_push_valid", {7'd0, push_valid}, 8'h00);
    chk("rst_int_busy", {7'd0, int_busy}, 8'h00);
    chk("rst_push_data", push_data, 8'h00);

    // ALU write: zero result with carry, N/Z/C masked in
    alu_valid = 1'b1; alu_dout = 8'h00; alu_carry = 1'b1; upd_mask = 8'h83;
    tick();
    chk("alu_nzc", status, 8'h37);

    // BIT: N,V from operand, Z from ALU result
    alu_valid = 1'b1; bit_test = 1'b1; bit_operand = 8'h40; alu_dout = 8'h05;
    alu_overflow = 1'b0; upd_mask = 8'hC2;
    tick();
    chk("bit_test", status, 8'h75);

    // SED alongside ALU carry write
    do_reset();
    flag_op = FLAG_OP_SED; alu_valid = 1'b1; upd_mask = 8'h01; alu_carry = 1'b1;
    tick();
    chk("sed_alu_status", status, 8'h3D);
    chk("sed_dec_mode", {7'd0, dec_mode}, 8'h01);

    // Pull overrides both flag_op and ALU
    pull_valid = 1'b1; pull_data = 8'hC3; alu_valid = 1'b1; upd_mask = 8'hFF;
    alu_dout = 8'h80; flag_op = FLAG_OP_SEI;
    tick();
    chk("pull_priority", status, 8'hF3);

    // CLI then IRQ with push_ack delayed 3 cycles
    do_reset();
    flag_op = FLAG_OP_CLI;
    tick();
    chk("cli_status", status, 8'h30);
    irq_req = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("irq_push_valid", {7'd0, push_valid}, 8'h01);
      chk("irq_push_data", push_data, 8'h20);
      // Updates attempted during PUSH must have no effect
      alu_valid = 1'b1; upd_mask = 8'hFF; alu_dout = 8'h80; alu_carry = 1'b1;
      flag_op = FLAG_OP_SED; pull_valid = 1'b1; pull_data = 8'hFF; irq_req = 1'b1;
      if (k == 2) push_ack = 1'b1;
      tick();
    end
    chk("mask_push_valid", {7'd0, push_valid}, 8'h00);
    chk("mask_int_busy", {7'd0, int_busy}, 8'h01);
    tick();
    chk("irq_done_status", status, 8'h34);
    chk("irq_done_busy", {7'd0, int_busy}, 8'h00);

    // D through interrupt entry
    do_reset();
    flag_op = FLAG_OP_SED;
    tick();
    flag_op = FLAG_OP_CLI;
    tick();
    irq_req = 1'b1;
    tick();
    chk("d_push_data", push_data, 8'h28);
    push_ack = 1'b1;
    tick();
    tick();
`ifdef STATUS_CMOS_DCLR_EN
    exp_d_after = 8'h34;
`else
    exp_d_after = 8'h3C;
`endif
    chk("d_after_mask", status, exp_d_after);

    // IRQ masked, then BRK, then reset mid-push
    do_reset();
    irq_req = 1'b1;
    tick();
    chk("irq_masked_no_push", {7'd0, push_valid}, 8'h00);
    chk("irq_masked_busy", {7'd0, int_busy}, 8'h00);
    brk_req = 1'b1;
    tick();
    chk("brk_push_data", push_data, 8'h34);
    chk("brk_busy", {7'd0, int_busy}, 8'h01);
    reset = 1'b1;
    tick();
    chk("rst_in_push_valid", {7'd0, push_valid}, 8'h00);
    chk("rst_in_push_busy", {7'd0, int_busy}, 8'h00);
    chk("rst_in_push_status", status, 8'h34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
